// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM status from the datapath in,
// stage-register enables, clears and performance counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src_a;
    logic [REG_ADDR_W-1:0] id_src_b;
    logic                  id_uses_b;
    logic                  id_halt;
    logic                  ex_valid;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  mem_branch_taken;
    logic                  mem_busy;

    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_clr;
    logic                  idex_clr;
    logic                  exmem_clr;
    logic                  halted;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_src_a, id_src_b, id_uses_b, id_halt,
        output ex_valid, ex_mem_read, ex_dest, mem_branch_taken, mem_busy,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_clr, idex_clr, exmem_clr, halted, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_src_a, id_src_b, id_uses_b, id_halt,
        input  ex_valid, ex_mem_read, ex_dest, mem_branch_taken, mem_busy,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_clr, idex_clr, exmem_clr, halted, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for a 5-stage pipeline: load-use stalls, MEM-resolved branch
// flushes, data-memory freeze, halt drain, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e                state_q;
    logic [DrainW-1:0]     drain_q;
    logic [CNT_W-1:0]      stall_q;
    logic [CNT_W-1:0]      flush_q;

    logic [REG_ADDR_W-1:0] src_a, src_b, ex_dest;
    logic                  lu, busy, br, halt_go;
    logic                  stall_inc, flush_inc;
    logic [4:0]            en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0]            clr;  // {ifid, idex, exmem}
    logic                  halted;

    assign src_a   = hz.id_src_a;
    assign src_b   = hz.id_src_b;
    assign ex_dest = hz.ex_dest;
    assign busy    = hz.mem_busy;
    assign br      = hz.mem_branch_taken;
    assign halt_go = hz.id_valid & hz.id_halt;

    always_comb begin
        lu = hz.ex_valid & hz.ex_mem_read & (ex_dest != '0) & hz.id_valid &
             ((src_a == ex_dest) | (hz.id_uses_b & (src_b == ex_dest)));
        en        = 5'b11111;
        clr       = 3'b000;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!reset) begin
            en  = 5'b00000;
            clr = 3'b111;
        end else begin
            unique case (state_q)
                StHalted: begin
                    en     = 5'b00000;
                    halted = 1'b1;
                end
                StRun, StDrain: begin
                    if (busy) begin
                        en        = 5'b00000;
                        stall_inc = 1'b1;
                    end else if (br) begin
                        clr       = 3'b111;
                        flush_inc = 1'b1;
                    end else if ((state_q == StDrain) || lu || halt_go) begin
                        // Hold PC and IF/ID, bubble into ID/EX, let older stages retire.
                        en        = 5'b00111;
                        clr       = 3'b010;
                        stall_inc = lu;
                    end
                end
                default: begin
                    en = 5'b00000;
                end
            endcase
        end
    end

    assign hz.pc_en       = en[4];
    assign hz.ifid_en     = en[3];
    assign hz.idex_en     = en[2];
    assign hz.exmem_en    = en[1];
    assign hz.memwb_en    = en[0];
    assign hz.ifid_clr    = clr[2];
    assign hz.idex_clr    = clr[1];
    assign hz.exmem_clr   = clr[0];
    assign hz.halted      = halted;
    assign hz.stall_count = stall_q;
    assign hz.flush_count = flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
            unique case (state_q)
                StRun: begin
                    if (!busy && !br && !lu && halt_go) begin
                        state_q <= StDrain;
                        drain_q <= DrainW'(DRAIN_CYCLES);
                    end
                end
                StDrain: begin
                    if (!busy) begin
                        if (br) begin
                            // Halt was fetched down the wrong path.
                            state_q <= StRun;
                            drain_q <= '0;
                        end else begin
                            drain_q <= drain_q - DrainW'(1);
                            if (drain_q == DrainW'(1)) state_q <= StHalted;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// expected outputs from a behavioural pipeline model pushed into a queue.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned AW  = 3;
    localparam int unsigned DC  = 3;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (AW),
        .DRAIN_CYCLES(DC),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    typedef struct {
        bit rst, idv, ub, halt, exv, exr, br, busy;
        int a, b, d;
    } in_t;

    typedef struct packed {
        logic [4:0]    en;
        logic [2:0]    clr;
        logic          halted;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: how many drain cycles remain, whether stopped, event tallies.
    int   m_drain  = 0;
    bit   m_halted = 1'b0;
    int   m_stall  = 0;
    int   m_flush  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endfunction

    function automatic in_t nop();
        in_t s;
        s.rst = 1; s.idv = 1; s.a = 1; s.b = 2; s.ub = 1; s.halt = 0;
        s.exv = 1; s.exr = 1; s.d = 5; s.br = 0; s.busy = 0;
        return s;
    endfunction

    task automatic apply(input in_t s);
        reset               = s.rst;
        hz.id_valid         = s.idv;
        hz.id_src_a         = AW'(s.a);
        hz.id_src_b         = AW'(s.b);
        hz.id_uses_b        = s.ub;
        hz.id_halt          = s.halt;
        hz.ex_valid         = s.exv;
        hz.ex_mem_read      = s.exr;
        hz.ex_dest          = AW'(s.d);
        hz.mem_branch_taken = s.br;
        hz.mem_busy         = s.busy;
    endtask

    task automatic step(input in_t s);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        apply(s);
        lu = s.exv && s.exr && (s.d != 0) && s.idv &&
             ((s.a == s.d) || (s.ub && (s.b == s.d)));
        e.stall  = CW'(m_stall);
        e.flush  = CW'(m_flush);
        e.halted = 1'b0;
        if (!s.rst) begin
            e.en = 5'b00000; e.clr = 3'b111; e.stall = '0; e.flush = '0;
            m_drain = 0; m_halted = 0; m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
            e.en = 5'b00000; e.clr = 3'b000; e.halted = 1'b1;
        end else if (s.busy) begin
            e.en = 5'b00000; e.clr = 3'b000;
            if (m_stall < SAT) m_stall++;
        end else if (s.br) begin
            e.en = 5'b11111; e.clr = 3'b111;
            if (m_flush < SAT) m_flush++;
            m_drain = 0;
        end else if (m_drain > 0) begin
            e.en = 5'b00111; e.clr = 3'b010;
            if (lu && m_stall < SAT) m_stall++;
            m_drain--;
            if (m_drain == 0) m_halted = 1;
        end else if (lu) begin
            e.en = 5'b00111; e.clr = 3'b010;
            if (m_stall < SAT) m_stall++;
        end else if (s.idv && s.halt) begin
            e.en = 5'b00111; e.clr = 3'b010;
            m_drain = DC;
        end else begin
            e.en = 5'b11111; e.clr = 3'b000;
        end
        q.push_back(e);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(nop());
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc++;
                chk("en{pc,ifid,idex,exmem,memwb}",
                    32'({hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en}), 32'(e.en));
                chk("clr{ifid,idex,exmem}",
                    32'({hz.ifid_clr, hz.idex_clr, hz.exmem_clr}), 32'(e.clr));
                chk("halted", 32'(hz.halted), 32'(e.halted));
                chk("stall_count", 32'(hz.stall_count), 32'(e.stall));
                chk("flush_count", 32'(hz.flush_count), 32'(e.flush));
            end
        end
    end

    initial begin
        in_t s;
        apply(nop());
        reset = 1'b1;
        #2 reset = 1'b0;

        // Power-on reset then release.
        s = nop(); s.rst = 0;
        step(s); step(s);
        nops(3);

        // Load-use via src_a, then dest 0 (no stall), then via src_b, then uses_b=0.
        s = nop(); s.d = 3; s.a = 3; step(s); nops(1);
        s = nop(); s.d = 0; s.a = 0; step(s); nops(1);
        s = nop(); s.d = 4; s.b = 4; step(s);
        s.ub = 0; step(s);
        s = nop(); s.d = 3; s.a = 3; s.idv = 0; step(s);
        s = nop(); s.idv = 0; s.halt = 1; step(s); nops(1);

        // Branch with load-use: flush wins, stall unchanged.
        s = nop(); s.d = 3; s.a = 3; s.br = 1; step(s); nops(1);

        // Memory busy four cycles with a pending branch, then the flush.
        s = nop(); s.br = 1; s.busy = 1;
        for (int i = 0; i < 4; i++) step(s);
        s.busy = 0; step(s); nops(2);

        // Reset mid-run clears counters.
        s = nop(); s.rst = 0; step(s); nops(2);

        // Halt drain, then halted holds against busy/branch/halt for 100 cycles.
        s = nop(); s.halt = 1; step(s);
        nops(DC);
        for (int i = 0; i < 100; i++) begin
            s = nop();
            s.busy = 1'($urandom_range(0, 1)); s.br = 1'($urandom_range(0, 1));
            s.halt = 1'($urandom_range(0, 1));
            step(s);
        end
        s = nop(); s.rst = 0; step(s); nops(1);

        // Busy in drain cycle 2 stretches the drain by one cycle.
        s = nop(); s.halt = 1; step(s);
        nops(1);
        s = nop(); s.busy = 1; step(s);
        nops(DC + 2);
        s = nop(); s.rst = 0; step(s); nops(1);

        // Wrong-path halt: branch in drain cycle 1 returns to run.
        s = nop(); s.halt = 1; step(s);
        s = nop(); s.br = 1; step(s);
        nops(6);

        // Counter saturation.
        s = nop(); s.busy = 1;
        for (int i = 0; i < SAT + 5; i++) step(s);
        s = nop(); s.br = 1;
        for (int i = 0; i < SAT + 5; i++) step(s);
        s = nop(); s.rst = 0; step(s);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 49) != 0);
            s.idv  = ($urandom_range(0, 7) != 0);
            s.a    = $urandom_range(0, 7);
            s.b    = $urandom_range(0, 7);
            s.ub   = 1'($urandom_range(0, 1));
            s.halt = ($urandom_range(0, 15) == 0);
            s.exv  = ($urandom_range(0, 7) != 0);
            s.exr  = 1'($urandom_range(0, 1));
            s.d    = $urandom_range(0, 7);
            s.br   = ($urandom_range(0, 7) == 0);
            s.busy = ($urandom_range(0, 5) == 0);
            step(s);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
